// File: rtl/data_arb_if.sv
// data_arb_if: producer handshakes, mode/tick controls and display outputs of data_arb
//   tick          one-clk enable from the slow-clock divider
//   modulo[1:0]   00 idle, 01 Fibonacci, 10 Timer, 11 round-robin
//   fib_req/fib_data/fib_ack  Fibonacci producer handshake
//   tmr_req/tmr_data/tmr_ack  Timer producer handshake
//   data_2/src    displayed word and its source id (01 fib, 10 tmr, 00 none)
//   full/empty    FIFO status
//   underrun_cnt  ticks that found the FIFO empty
interface data_arb_if #(parameter int CNT_W = 8);
   logic             tick;
   logic [1:0]       modulo;
   logic             fib_req;
   logic [15:0]      fib_data;
   logic             fib_ack;
   logic             tmr_req;
   logic [15:0]      tmr_data;
   logic             tmr_ack;
   logic [15:0]      data_2;
   logic [1:0]       src;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] underrun_cnt;
   modport slave (
      input  tick, modulo, fib_req, fib_data, tmr_req, tmr_data,
      output fib_ack, tmr_ack, data_2, src, full, empty, underrun_cnt
   );
   modport master (
      output tick, modulo, fib_req, fib_data, tmr_req, tmr_data,
      input  fib_ack, tmr_ack, data_2, src, full, empty, underrun_cnt
   );
endinterface

// File: rtl/data_arb.sv
// data_arb: arbitrates Fibonacci/Timer words into a FIFO and releases one word per tick
//   clk  system clock
//   rst  asynchronous active-low reset
//   b    data_arb_if.slave: tick, modulo, producer handshakes, data_2/src, full/empty, underrun_cnt
//   DATA_ARB_UNDERRUN_CNT_EN  when defined, underrun_cnt counts empty ticks; otherwise it is tied to 0
module data_arb #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input logic       clk,
   input logic       rst,
   data_arb_if.slave b
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   logic [17:0]   mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [OW-1:0] occ;
   logic [1:0]    mode, src;
   logic [15:0]   data;
   logic          flush, last_tmr, fib_ack, tmr_ack;
   logic          go, act, full, empty, fib_el, tmr_el, gnt_f, gnt_t, push, pop;
   assign full  = occ == OW'(DEPTH);
   assign empty = occ == '0;
   // nothing is granted or popped while a mode change is pending or being flushed
   assign go     = (b.modulo == mode) && !flush;
   assign act    = mode != 2'b00;
   assign fib_el = b.fib_req && mode[0] && !full && !fib_ack;
   assign tmr_el = b.tmr_req && mode[1] && !full && !tmr_ack;
   assign gnt_f  = go && fib_el && (!tmr_el || last_tmr);
   assign gnt_t  = go && tmr_el && !gnt_f;
   assign push   = gnt_f || gnt_t;
   assign pop    = go && act && b.tick && !empty;
   always_ff @(posedge clk)
      if (push) mem[wp] <= {gnt_t, gnt_f, gnt_t ? b.tmr_data : b.fib_data};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mode     <= 2'b00;
         flush    <= 1'b0;
         last_tmr <= 1'b1;
         fib_ack  <= 1'b0;
         tmr_ack  <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         occ      <= '0;
         data     <= '0;
         src      <= 2'b00;
      end else begin
         mode    <= b.modulo;
         flush   <= b.modulo != mode;
         fib_ack <= gnt_f;
         tmr_ack <= gnt_t;
         if (push) last_tmr <= gnt_t;
         if (flush) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
         end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) begin
               rp   <= rp + AW'(1);
               data <= mem[rp][15:0];
               src  <= mem[rp][17:16];
            end
            occ <= occ + OW'(push) - OW'(pop);
         end
      end
   assign b.fib_ack = fib_ack;
   assign b.tmr_ack = tmr_ack;
   assign b.data_2  = data;
   assign b.src     = src;
   assign b.full    = full;
   assign b.empty   = empty;
`ifdef DATA_ARB_UNDERRUN_CNT_EN
   logic [CNT_W-1:0] ucnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) ucnt <= '0;
      else if (go && act && b.tick && empty && ucnt != '1) ucnt <= ucnt + CNT_W'(1);
   assign b.underrun_cnt = ucnt;
`else
   assign b.underrun_cnt = CNT_W'(0);
`endif
endmodule
